// File: rtl/data_mem_ctrl_pkg.sv
// Shared constants, state codes and helpers for the data-memory controller.
// Imported by dmem_array and data_mem_ctrl.
package data_mem_ctrl_pkg;

  localparam logic ENABLE        = 1'b1;
  localparam logic DISABLE       = 1'b0;
  localparam int   REG_LENGTH    = 32;
  localparam int   DMEM_WAIT_LEN = 4;

  typedef enum logic [1:0] {
    DMEM_IDLE   = 2'd0,
    DMEM_ACCESS = 2'd1,
    DMEM_DONE   = 2'd2
  } dmem_state_e;

  // Word aligned and word index below 2**aw.
  function automatic logic addr_ok(
    input logic [REG_LENGTH-1:0] a,
    input int                    aw
  );
    return (a[1:0] == 2'b00) && ((a >> (aw + 2)) == 32'd0);
  endfunction

endpackage

// File: rtl/data_mem_ctrl_array.sv
// dmem_array: DEPTH x 32 word RAM, sync write with 4 byte lanes, sync read.
// Ports: clk, we_i, be_i (bit3 = [31:24]), waddr_i, wdata_i, raddr_i, rdata_o.
module dmem_array
  import data_mem_ctrl_pkg::*;
#(
  parameter int    DEPTH     = 1024,
  parameter string INIT_FILE = "",
  localparam int   AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [REG_LENGTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [REG_LENGTH-1:0] rdata_o
);

  logic [REG_LENGTH-1:0] mem [DEPTH];
  logic [REG_LENGTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: FSM, wait-state counter, range check, outputs.
// Ports: clk, rst, memCe/memWr/memAddr/wtData/byteEn in; rdData/rdy/err/stall out.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int    DEPTH       = 1024,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memCe,
  input  logic                  memWr,
  input  logic [REG_LENGTH-1:0] memAddr,
  input  logic [REG_LENGTH-1:0] wtData,
  input  logic [3:0]            byteEn,
  output logic [REG_LENGTH-1:0] rdData,
  output logic                  rdy,
  output logic                  err,
  output logic                  stall
);

  localparam int AW = $clog2(DEPTH);

  dmem_state_e state_q, state_d;
  logic [DMEM_WAIT_LEN-1:0] cnt_q, cnt_d;
  logic [REG_LENGTH-1:0] addr_q, addr_d;
  logic [REG_LENGTH-1:0] data_q, data_d;
  logic [3:0] be_q, be_d;
  logic wr_q, wr_d;
  logic [REG_LENGTH-1:0] rd_q, rd_d;
  logic rdy_q, rdy_d;
  logic err_q, err_d;

  logic commit;
  logic ok;
  logic we;
  logic [AW-1:0] raddr;
  logic [REG_LENGTH-1:0] ram_q;

  assign ok = addr_ok(addr_q, AW);

  // In IDLE the RAM reads the incoming address so the word is ready
  // by the first ACCESS cycle, even with zero wait states.
  assign raddr = (state_q == DMEM_IDLE) ? memAddr[AW+1:2]
                                        : addr_q[AW+1:2];

  // A reset on the commit edge must also cancel the write.
  assign we = commit && ok && wr_q && !rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    rdy_d   = 1'b0;
    err_d   = 1'b0;
    commit  = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      DMEM_IDLE: begin
        stall = memCe;
        if (memCe == ENABLE) begin
          addr_d  = memAddr;
          data_d  = wtData;
          be_d    = byteEn;
          wr_d    = memWr;
          cnt_d   = DMEM_WAIT_LEN'(WAIT_CYCLES);
          state_d = DMEM_ACCESS;
        end
      end
      DMEM_ACCESS: begin
        stall = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          commit  = 1'b1;
          rdy_d   = 1'b1;
          err_d   = !ok;
          state_d = DMEM_DONE;
          if (!ok) rd_d = '0;
          else if (wr_q == DISABLE) rd_d = ram_q;
        end
      end
      DMEM_DONE: state_d = DMEM_IDLE;
      default:   state_d = DMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
      rd_q    <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  dmem_array #(
    .DEPTH    (DEPTH),
    .INIT_FILE(INIT_FILE)
  ) u_array (
    .clk    (clk),
    .we_i   (we),
    .be_i   (be_q),
    .waddr_i(addr_q[AW+1:2]),
    .wdata_i(data_q),
    .raddr_i(raddr),
    .rdata_o(ram_q)
  );

  assign rdData = rd_q;
  assign rdy    = rdy_q;
  assign err    = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two instances (2 and 0 wait states), a
// transaction-level reference model, per-cycle compare and literal checks.
module tb_data_mem_ctrl;

  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst;
  logic        ce   [2];
  logic        wr   [2];
  logic [31:0] addr [2];
  logic [31:0] wd   [2];
  logic [3:0]  be   [2];
  logic [31:0] rdat [2];
  logic        rdyo [2];
  logic        erro [2];
  logic        stl  [2];

  int cyc = 0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(2), .INIT_FILE("")) u_w2 (
    .clk(clk), .rst(rst), .memCe(ce[0]), .memWr(wr[0]),
    .memAddr(addr[0]), .wtData(wd[0]), .byteEn(be[0]),
    .rdData(rdat[0]), .rdy(rdyo[0]), .err(erro[0]), .stall(stl[0])
  );

  data_mem_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .INIT_FILE("")) u_w0 (
    .clk(clk), .rst(rst), .memCe(ce[1]), .memWr(wr[1]),
    .memAddr(addr[1]), .wtData(wd[1]), .byteEn(be[1]),
    .rdData(rdat[1]), .rdy(rdyo[1]), .err(erro[1]), .stall(stl[1])
  );

  function automatic int wcyc(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string nm, input int d,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%h exp=%h", nm, d, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mdl [longint];
  bit          busy [2];
  int          acc  [2];
  logic        mwr  [2];
  logic [31:0] maddr[2];
  logic [31:0] mdata[2];
  logic [3:0]  mbe  [2];
  logic [31:0] erd  [2];
  bit          erdk [2];
  bit          eerr [2];
  bit          live = 0;

  task automatic do_commit(input int d);
    longint key;
    logic [31:0] v;
    key = longint'(d) * 64'h1_0000_0000 + longint'(maddr[d] >> 2);
    if ((maddr[d] % 4) != 0 || (maddr[d] >> 2) >= DEPTH) begin
      eerr[d] = 1;
      erd[d]  = 0;
      erdk[d] = 1;
    end else begin
      eerr[d] = 0;
      if (mwr[d]) begin
        if (mbe[d] == 4'hF) mdl[key] = mdata[d];
        else if (mdl.exists(key)) begin
          v = mdl[key];
          for (int i = 0; i < 4; i++)
            if (mbe[d][i]) v[8*i +: 8] = mdata[d][8*i +: 8];
          mdl[key] = v;
        end
      end else if (mdl.exists(key)) begin
        erd[d]  = mdl[key];
        erdk[d] = 1;
      end else begin
        erdk[d] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit dn;
      dn = busy[d] && (cyc == acc[d] + 2 + wcyc(d));
      if (live) begin
        chk("stall", d, {31'b0, stl[d]},
            {31'b0, busy[d] ? !dn : ce[d]});
        chk("rdy", d, {31'b0, rdyo[d]}, {31'b0, dn});
        chk("err", d, {31'b0, erro[d]}, {31'b0, dn && eerr[d]});
        if (erdk[d]) chk("rdData", d, rdat[d], erd[d]);
      end
      if (rst) begin
        busy[d] = 0;
        erd[d]  = 0;
        erdk[d] = 1;
      end else if (busy[d]) begin
        if (cyc == acc[d] + 1 + wcyc(d)) do_commit(d);
        else if (dn) busy[d] = 0;
      end else if (ce[d]) begin
        busy[d]  = 1;
        acc[d]   = cyc;
        mwr[d]   = wr[d];
        maddr[d] = addr[d];
        mdata[d] = wd[d];
        mbe[d]   = be[d];
      end
    end
    if (rst) live = 1;
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    ce[0] = 0;
    ce[1] = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic req(input int d, input logic w, input logic [31:0] a,
                     input logic [31:0] dat, input logic [3:0] b,
                     input bit churn, output logic [31:0] rd_o,
                     output logic err_o, output logic st_o,
                     output int rc);
    int n;
    bit got;
    ce[d] = 1;
    wr[d] = w;
    addr[d] = a;
    wd[d] = dat;
    be[d] = b;
    n = 0;
    got = 0;
    rd_o = 'x;
    err_o = 1'bx;
    st_o = 1'bx;
    rc = -1;
    while (!got && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (rdyo[d]) begin
        got = 1;
        rd_o = rdat[d];
        err_o = erro[d];
        st_o = stl[d];
        rc = cyc;
      end else if (churn && busy[d]) begin
        addr[d] = $urandom();
        wd[d] = $urandom();
        be[d] = 4'($urandom());
        wr[d] = 1'($urandom());
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL timeout dut%0d addr=%h got=no_rdy exp=rdy", d, a);
    end
  endtask

  logic [31:0] r;
  logic e, s;
  int rc, st, r1, r2, r3;

  initial begin
    rst = 1;
    for (int d = 0; d < 2; d++) begin
      ce[d] = 0; wr[d] = 0; addr[d] = 0; wd[d] = 0; be[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    chk("rst_rdData", 0, rdat[0], 32'h0);
    chk("rst_rdy", 0, {31'b0, rdyo[0]}, 32'h0);

    // word 5 then read with 2 wait states
    req(0, 1, 32'h14, 32'h12345678, 4'hF, 0, r, e, s, rc);
    idle(1);
    st = cyc;
    req(0, 0, 32'h14, 0, 4'h0, 0, r, e, s, rc);
    chk("rd5_data", 0, r, 32'h12345678);
    chk("rd5_err", 0, {31'b0, e}, 32'h0);
    chk("rd5_stall", 0, {31'b0, s}, 32'h0);
    chk("rd5_lat", 0, rc - st, 4);
    idle(1);

    // lane write
    req(0, 1, 32'h20, 32'hAABBCCDD, 4'b1111, 0, r, e, s, rc);
    req(0, 1, 32'h20, 32'h11223344, 4'b0101, 0, r, e, s, rc);
    req(0, 0, 32'h20, 0, 4'h0, 0, r, e, s, rc);
    chk("lane_rd", 0, r, 32'hAA22CC44);

    // misaligned
    req(0, 0, 32'h22, 0, 4'h0, 0, r, e, s, rc);
    chk("mis_err", 0, {31'b0, e}, 32'h1);
    chk("mis_rd", 0, r, 32'h0);
    req(0, 0, 32'h20, 0, 4'h0, 0, r, e, s, rc);
    chk("mis_reread", 0, r, 32'hAA22CC44);

    // out of range aliasing word 0
    req(0, 1, 32'h0, 32'hCAFEF00D, 4'hF, 0, r, e, s, rc);
    req(0, 1, 32'h1000, 32'h55555555, 4'hF, 0, r, e, s, rc);
    chk("oor_err", 0, {31'b0, e}, 32'h1);
    req(0, 0, 32'h0, 0, 4'h0, 0, r, e, s, rc);
    chk("oor_w0", 0, r, 32'hCAFEF00D);

    // reset in ACCESS
    req(0, 1, 32'h40, 32'h0BADF00D, 4'hF, 0, r, e, s, rc);
    idle(1);
    ce[0] = 1; wr[0] = 1; addr[0] = 32'h40; wd[0] = 32'hDEADBEEF; be[0] = 4'hF;
    @(posedge clk); #1;
    ce[0] = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("arst_rdy", 0, {31'b0, rdyo[0]}, 32'h0);
    chk("arst_err", 0, {31'b0, erro[0]}, 32'h0);
    chk("arst_rd", 0, rdat[0], 32'h0);
    chk("arst_stall", 0, {31'b0, stl[0]}, 32'h0);
    idle(2);
    req(0, 0, 32'h40, 0, 4'h0, 0, r, e, s, rc);
    chk("arst_old", 0, r, 32'h0BADF00D);
    idle(1);

    // reset on the commit edge (ACCESS cycles 1..3)
    ce[0] = 1; wr[0] = 1; addr[0] = 32'h40; wd[0] = 32'h12121212; be[0] = 4'hF;
    @(posedge clk); #1;
    ce[0] = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("crst_rdy", 0, {31'b0, rdyo[0]}, 32'h0);
    idle(2);
    req(0, 0, 32'h40, 0, 4'h0, 0, r, e, s, rc);
    chk("crst_old", 0, r, 32'h0BADF00D);
    idle(2);

    // zero wait states, back-to-back with churn
    req(1, 1, 32'h8, 32'h01020304, 4'hF, 0, r, e, s, rc);
    idle(2);
    st = cyc;
    req(1, 0, 32'h8, 0, 4'h0, 1, r, e, s, r1);
    chk("b2b_rd1", 1, r, 32'h01020304);
    req(1, 1, 32'h8, 32'hA5A5A5A5, 4'hF, 1, r, e, s, r2);
    req(1, 0, 32'h8, 0, 4'h0, 1, r, e, s, r3);
    chk("b2b_rd2", 1, r, 32'hA5A5A5A5);
    chk("b2b_t1", 1, r1 - st, 2);
    chk("b2b_t2", 1, r2 - st, 5);
    chk("b2b_t3", 1, r3 - st, 8);
    idle(2);

    // randomized traffic against the model
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 16; w++)
        req(d, 1, 32'(w * 4), $urandom(), 4'hF, 0, r, e, s, rc);
    for (int k = 0; k < 60; k++) begin
      int d, sel, w;
      logic [31:0] a;
      d = k % 2;
      sel = $urandom_range(0, 9);
      w = $urandom_range(0, 15);
      if (sel <= 6) a = 32'(w * 4);
      else if (sel == 7) a = 32'(w * 4 + $urandom_range(1, 3));
      else if (sel == 8) a = 32'h1000 + 32'(w * 4);
      else a = $urandom();
      req(d, 1'($urandom()), a, $urandom(), 4'($urandom()),
          1'($urandom()), r, e, s, rc);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
